lsu_memif: RTL
==============

Name: lsu_memif

Overview:
- Initiator side of the core's memory interface: the load/store unit that sits between the execute stage and the memory controller.
- Accepts one load/store request at a time from the pipeline and checks alignment.
- Drives the mem_addr / mem_read_valid / mem_write_valid / mem_width bus and waits for mem_ready.
- Sign/zero-extends load data and returns a single-cycle response, with a watchdog that faults accesses to unmapped addresses (which never assert mem_ready).

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for mem_ready before access fault; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  pipeline request present
- req_ready  output  1  LSU can accept a request this cycle
- req_write  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_width  input  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_misaligned  output  1  valid with resp_valid: alignment/width fault
- resp_access_fault  output  1  valid with resp_valid: watchdog expired
- mem_addr  output  32  memory address
- mem_read_valid  output  1  read request
- mem_write_valid  output  1  write request
- mem_write_data  output  32  store data, right-aligned, unused upper bits 0
- mem_width  output  2  access width, same encoding as req_width
- mem_read_data  input  32  read data, right-aligned
- mem_ready  input  1  transaction completes this cycle

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (rst low), asynchronous: state=IDLE. All of the following are 0: mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width, resp_valid, resp_rdata, resp_misaligned, resp_access_fault, watchdog count. req_ready is forced 0 while rst is low.
- req_ready = (state==IDLE) && rst high, combinational.
- Accept: on the edge where req_valid && req_ready, latch write, addr, wdata, width, unsigned.
- Misaligned if any of:
  - width==3
  - width==1 && addr[0]
  - width==2 && addr[1:0]!=0
- On misaligned: go to RESP with resp_misaligned=1 and no memory access.
- Otherwise go to BUSY and clear the watchdog.
- BUSY outputs, registered and stable for the whole state:
  - mem_addr = latched addr; mem_width = latched width.
  - mem_write_data = wdata masked to width: byte {24'b0,wdata[7:0]}, half {16'b0,wdata[15:0]}.
  - Exactly one of mem_read_valid / mem_write_valid = 1.
- BUSY transitions:
  - mem_ready=1 at an edge: completion. A load captures extended mem_read_data. Go to RESP.
  - mem_ready=0: watchdog increments. When TIMEOUT!=0 and the count reaches TIMEOUT, go to RESP with resp_access_fault=1, rdata=0, and no data capture. The mem valid is dropped.
- Load extension: byte uses [7:0], half uses [15:0], word is passed through. Upper bits are replicated from the top data bit, or zero when unsigned.
- RESP: resp_valid=1 for exactly one cycle with rdata/flags stable; mem valids=0 and mem_addr/mem_width/mem_write_data=0. Next state is IDLE.
- In IDLE all resp_* outputs are 0.
- Latency:
  - Accept at edge N; mem valid is high during cycle N+1.
  - Zero-wait mem_ready gives resp_valid in cycle N+2 and req_ready again in N+3.
  - Misaligned gives resp_valid in N+1.
- mem_ready outside BUSY is ignored. mem_read_data is ignored except at a load completion edge.
- Fault flags are mutually exclusive. Store responses have resp_rdata=0.
- Reset asserted mid-BUSY: mem valids drop immediately (asynchronously). No response is issued.
- Timeout and mem_ready on the same edge: mem_ready wins, giving normal completion.
- Watchdog counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Test Plan:
- Load word 0x1004 with mem_ready high in the first BUSY cycle, mem_read_data=0xDEADBEEF -> mem_read_valid high exactly 1 cycle, mem_width=2; resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, flags 0.
- Load byte 0x1001 signed, then unsigned, with mem_read_data=0x000000F0 -> resp_rdata 0xFFFFFFF0, then 0x000000F0. Repeat as half with 0x00008001 -> 0xFFFF8001, then 0x00008001.
- Store half 0x1002, wdata=0x12345678, mem_ready delayed 3 cycles -> mem_write_valid, mem_addr, mem_write_data=0x00005678 stable all 4 BUSY cycles; req_ready low throughout; resp_rdata=0.
- Misaligned word load at 0x1002, and width=3 at 0x0 -> resp_misaligned=1 one cycle after accept; mem_read_valid and mem_write_valid never assert.
- Load from 0x5000 with mem_ready held low, TIMEOUT=16 -> mem_read_valid high exactly 16 cycles, then resp_access_fault=1, rdata=0. With TIMEOUT=0 -> waits indefinitely.
- Assert rst low mid-BUSY -> mem valids 0 in the same cycle without a clock edge; no resp_valid; after release req_ready=1 and a new word read completes normally.

Source files
------------

// File: rtl/lsu_memif_if.sv
// Bundles the pipeline request/response handshake and the memory bus of the
// load/store unit. The LSU is the master; the pipeline and memory controller
// together form the slave side.
interface lsu_memif_if;
    // pipeline request
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_unsigned;
    // pipeline response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_access_fault;
    // memory bus
    logic [31:0] mem_addr;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_width;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_width, req_unsigned,
        output req_ready,
        output resp_valid, resp_rdata, resp_misaligned, resp_access_fault,
        output mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width,
        input  mem_read_data, mem_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_width, req_unsigned,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misaligned, resp_access_fault,
        input  mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/lsu_memif.sv
// Load/store unit memory initiator: accepts one request at a time, checks
// alignment, runs a single memory transaction with a watchdog, and returns a
// one-cycle response with sign/zero-extended load data.
module lsu_memif #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    lsu_memif_if.master bus
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            lat_unsigned;
    logic            accept, misaligned, expired;

    // Right-aligned data masked to the access width (store data path).
    function automatic logic [31:0] mask_width(input logic [31:0] d, input logic [1:0] w);
        case (w)
            2'd0:    return {24'b0, d[7:0]};
            2'd1:    return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Sign- or zero-extension of right-aligned load data.
    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] w,
                                           input logic u);
        case (w)
            2'd0:    return {{24{~u & d[7]}}, d[7:0]};
            2'd1:    return {{16{~u & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misaligned ? RESP : BUSY;
            BUSY:    if (bus.mem_ready || expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs and decode of handshake/alignment/watchdog events.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.req_ready = (state == IDLE) && rst;
        accept        = bus.req_valid && bus.req_ready;
        misaligned    = 1'b0;
        case (bus.req_width)
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        // mem_ready on the same edge takes priority over the timeout.
        expired = (TIMEOUT != 0) && !bus.mem_ready && (wd_cnt == WD_LAST);
    end

    // Registered memory bus, response and watchdog. The asynchronous reset
    // drops the mem valids immediately if reset hits mid-transaction. During
    // BUSY the registered mem_width / mem_read_valid double as the latched
    // width and direction of the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_addr          <= '0;
            bus.mem_read_valid    <= 1'b0;
            bus.mem_write_valid   <= 1'b0;
            bus.mem_write_data    <= '0;
            bus.mem_width         <= '0;
            bus.resp_valid        <= 1'b0;
            bus.resp_rdata        <= '0;
            bus.resp_misaligned   <= 1'b0;
            bus.resp_access_fault <= 1'b0;
            wd_cnt                <= '0;
            lat_unsigned          <= 1'b0;
        end else begin
            // Responses are single-cycle pulses; RESP never lasts longer.
            bus.resp_valid        <= 1'b0;
            bus.resp_rdata        <= '0;
            bus.resp_misaligned   <= 1'b0;
            bus.resp_access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_unsigned <= bus.req_unsigned;
                        wd_cnt       <= '0;
                        if (misaligned) begin
                            bus.resp_valid      <= 1'b1;
                            bus.resp_misaligned <= 1'b1;
                        end else begin
                            bus.mem_addr        <= bus.req_addr;
                            bus.mem_width       <= bus.req_width;
                            bus.mem_write_data  <= mask_width(bus.req_wdata, bus.req_width);
                            bus.mem_read_valid  <= !bus.req_write;
                            bus.mem_write_valid <= bus.req_write;
                        end
                    end
                end
                BUSY: begin
                    if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
                    if (bus.mem_ready || expired) begin
                        bus.resp_valid        <= 1'b1;
                        bus.resp_access_fault <= !bus.mem_ready;
                        if (bus.mem_ready && bus.mem_read_valid)
                            bus.resp_rdata <= extend(bus.mem_read_data, bus.mem_width, lat_unsigned);
                        bus.mem_addr        <= '0;
                        bus.mem_read_valid  <= 1'b0;
                        bus.mem_write_valid <= 1'b0;
                        bus.mem_write_data  <= '0;
                        bus.mem_width       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
